// File: rtl/pulse_evt_pkg.sv
// Shared types and constants for the pulse event register block.
// PULSE_EVT_LONGPRESS_EN adds the HELD state used for long-press detection.
package pulse_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1
`ifdef PULSE_EVT_LONGPRESS_EN
        ,
        ST_HELD    = 2'd2
`endif
    } press_state_e;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STS_PENDING = 0;
    localparam int STS_LEVEL   = 1;
    localparam int STS_OVF     = 2;
    localparam int STS_LONG    = 3;

endpackage

// File: rtl/press_fsm.sv
// Rising-edge detector and press FSM producing press / long-press strobes.
// Hold counter and HELD state exist only with PULSE_EVT_LONGPRESS_EN defined.
module press_fsm
    import pulse_evt_pkg::*;
#(
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic level_q_o,
    output logic press_o,
    output logic long_o
);

    logic         prev_q;
    logic         armed_q;
    press_state_e state_q;

    // armed_q stays low until a low level is seen, so a button already held
    // when reset releases is not counted.
    assign press_o   = level_i & ~prev_q & armed_q;
    assign level_q_o = prev_q;

`ifdef PULSE_EVT_LONGPRESS_EN
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    logic [HOLD_W-1:0] hold_q;

    assign long_o = (state_q == ST_PRESSED) && level_i &&
                    (hold_q == HOLD_W'(HOLD_CYC - 1));
`else
    localparam int unused_hold_cyc = HOLD_CYC;

    assign long_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
`ifdef PULSE_EVT_LONGPRESS_EN
            hold_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates make every register here sample pre-edge values.
            prev_q <= level_i;
            if (!level_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (press_o) begin
                        state_q <= ST_PRESSED;
                    end
`ifdef PULSE_EVT_LONGPRESS_EN
                    hold_q <= press_o ? HOLD_W'(1) : '0;
`endif
                end
                ST_PRESSED: begin
                    if (!level_i) begin
                        state_q <= ST_IDLE;
`ifdef PULSE_EVT_LONGPRESS_EN
                    end else if (long_o) begin
                        state_q <= ST_HELD;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
`endif
                    end
                end
`ifdef PULSE_EVT_LONGPRESS_EN
                ST_HELD: begin
                    if (!level_i) begin
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pulse_event_reg.sv
// CPU register file (STATUS / COUNT / CTRL) and interrupt around press_fsm.
// Defining PULSE_EVT_LONGPRESS_EN enables STATUS.longpress and its interrupt.
module pulse_event_reg
    import pulse_evt_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        detected_pulse,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic             press;
    logic             long_strobe;
    logic             level_q;
    logic             pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             long_flag;
    logic             wr_status, wr_count, wr_ctrl;

    press_fsm #(
        .HOLD_CYC (HOLD_CYC)
    ) u_press_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_i   (detected_pulse),
        .level_q_o (level_q),
        .press_o   (press),
        .long_o    (long_strobe)
    );

    assign wr_status = we && (addr == ADDR_STATUS);
    assign wr_count  = we && (addr == ADDR_COUNT);
    assign wr_ctrl   = we && (addr == ADDR_CTRL);

    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        pending_d = pending_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        irq_en_d  = irq_en_q;
        if (wr_status && wdata[STS_PENDING]) pending_d = 1'b0;
        if (wr_status && wdata[STS_OVF])     ovf_d     = 1'b0;
        if (wr_count)                        count_d   = '0;
        if (wr_ctrl)                         irq_en_d  = wdata[0];
        // A press overrides same-cycle software clears; a COUNT clear plus a
        // press therefore lands on 1 and is not a wrap.
        if (press) begin
            pending_d = 1'b1;
            count_d   = count_d + CNT_W'(1);
            if (!wr_count && (&count_q)) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            count_q   <= count_d;
        end
    end

`ifdef PULSE_EVT_LONGPRESS_EN
    logic long_q, long_d;

    always_comb begin
        long_d = long_q;
        if (wr_status && wdata[STS_LONG]) long_d = 1'b0;
        if (long_strobe)                  long_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_q <= 1'b0;
        end else begin
            long_q <= long_d;
        end
    end

    assign long_flag = long_q;
`else
    assign long_flag = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{wdata[31:3], wdata[1], long_strobe};

    assign irq = irq_en_q & (pending_q | long_flag);

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_STATUS: begin
                rdata[STS_PENDING] = pending_q;
                rdata[STS_LEVEL]   = level_q;
                rdata[STS_OVF]     = ovf_q;
                rdata[STS_LONG]    = long_flag;
            end
            ADDR_COUNT: rdata[CNT_W-1:0] = count_q;
            ADDR_CTRL:  rdata[0]         = irq_en_q;
            default:    rdata            = '0;
        endcase
    end

endmodule

// File: doc/pulse_event_reg.md
PULSE_EVENT_REG -- requirements
Module: pulse_event_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the press counter.
REQ-002 SHALL have parameter HOLD_CYC, default 50_000_000: number of cycles of continuous high level that constitutes a long press.
REQ-003 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port detected_pulse, input, 1: debounced button level from the debounce stage, already synchronous to clk.
REQ-006 SHALL have port we, input, 1: CPU write strobe.
REQ-007 SHALL have port addr, input, 2: register select (0 STATUS, 1 COUNT, 2 CTRL, 3 reserved).
REQ-008 SHALL have port wdata, input, 32: CPU write data.
REQ-009 SHALL have port rdata, output, 32: combinational read data for addr.
REQ-010 SHALL have port irq, output, 1: level interrupt request to the core.

Function
REQ-011 SHALL register detected_pulse once (prev) and detect a press as detected_pulse=1 with prev=0.
REQ-012 SHALL run a press FSM with states IDLE and PRESSED (plus HELD under the macro):
- IDLE->PRESSED on a press.
- PRESSED->IDLE when the level drops.
REQ-013 On each press, SHALL set STATUS.pending (bit0) in the following cycle and increment COUNT by 1.
REQ-014 COUNT SHALL wrap from 2^CNT_W-1 to 0 and set STATUS.ovf (bit2) on the same edge.
REQ-015 STATUS.level (bit1) SHALL read the registered level (prev).
REQ-016 Writing STATUS with a 1 in bit0, bit2 or bit3 SHALL clear that bit (W1C); 0 bits SHALL leave the flag unchanged.
REQ-017 Writing COUNT (any data) SHALL clear COUNT to 0.
REQ-018 CTRL bit0 SHALL be irq_en (read/write); all other CTRL bits SHALL read 0.
REQ-019 irq SHALL equal irq_en AND (pending OR longpress).
REQ-020 If a press and a W1C of pending occur in the same cycle, set SHALL win and pending SHALL remain 1.
REQ-021 If a press and a COUNT write occur in the same cycle, COUNT SHALL become 1.
REQ-022 Reads SHALL have no side effects.
REQ-023 Reserved address SHALL read 0 and ignore writes.
REQ-024 Unused rdata bits SHALL read 0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force all of the following, regardless of clk:
- FSM to IDLE; prev, pending, ovf, longpress, irq_en and COUNT to 0.
- irq=0; rdata per cleared registers.
REQ-026 After rst_n deasserts with detected_pulse already 1, no press SHALL be counted until the level falls and rises again.

Configuration
REQ-027 With PULSE_EVT_LONGPRESS_EN defined, the block SHALL contain a hold counter and state HELD:
- PRESSED->HELD after HOLD_CYC consecutive high cycles, setting STATUS.longpress (bit3) once.
- HELD->IDLE when the level drops.
- Counter cleared in IDLE.
REQ-028 Without PULSE_EVT_LONGPRESS_EN, the block SHALL have no HELD state and no hold counter; bit3 SHALL read 0, W1C on bit3 SHALL be ignored, and irq SHALL depend on pending only.

Structure
REQ-029 A shared package pulse_evt_pkg SHALL hold:
- The FSM state enum.
- Register address constants (STATUS, COUNT, CTRL).
- STATUS bit-index constants.
REQ-030 The edge detector plus press FSM SHALL be one sub-module, press_fsm, outputting press and long-press strobes; the register file SHALL stay in pulse_event_reg.

Verification
REQ-031 Reset, then three high pulses of 5 cycles, each separated by 5 low cycles -> COUNT=3, pending=1, irq=0 (irq_en=0).
REQ-032 Write CTRL=1, then one press -> irq=1 the cycle after pending sets; W1C STATUS=0x1 -> pending=0, irq=0.
REQ-033 Preload 255 presses (CNT_W=8), then one more -> COUNT=0, ovf=1; write COUNT -> COUNT=0, ovf still 1.
REQ-034 Press and W1C pending in the same cycle -> pending=1; press and COUNT write in the same cycle -> COUNT=1.
REQ-035 With the macro, HOLD_CYC=10 and the level high for 15 cycles -> longpress=1 exactly once and COUNT=1; without the macro -> bit3=0.
REQ-036 Assert rst_n low mid-press while the level stays high, then release -> all registers 0, no count until a new rising edge.
